four_bit_adder: RTL and testbench
=================================

FOUR_BIT_ADDER -- requirements
Module: four_bit_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and sum width (legal range 1..16; all values in this document assume 4).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port A, input, WIDTH bits: unsigned operand A.
REQ-005 The block SHALL have port B, input, WIDTH bits: unsigned operand B.
REQ-006 The block SHALL have port Cin, input, 1 bit: carry-in.
REQ-007 The block SHALL have port in_valid, input, 1 bit: high when A, B and Cin hold a request to capture this cycle.
REQ-008 The block SHALL have port Sum, output, WIDTH bits: registered result, equal to (A+B+Cin) mod 2^WIDTH.
REQ-009 The block SHALL have port Cout, output, 1 bit: registered carry-out, bit WIDTH of A+B+Cin.
REQ-010 The block SHALL have port Ovf, output, 1 bit: registered two's-complement overflow flag.
REQ-011 The block SHALL have port Zero, output, 1 bit: registered flag, high when Sum is all zeros.
REQ-012 The block SHALL have port out_valid, output, 1 bit: high when Sum, Cout, Ovf and Zero hold a new result.

Function
REQ-013 The datapath SHALL be a ripple-carry chain of WIDTH full-adder cells: s_i = a_i^b_i^c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i); c_0 = Cin.
REQ-014 Cout SHALL equal c_WIDTH; {Cout,Sum} SHALL equal A+B+Cin exactly, range 0..2^(WIDTH+1)-1 (0..31 for WIDTH 4).
REQ-015 Ovf SHALL equal c_WIDTH XOR c_(WIDTH-1).
REQ-016 Zero SHALL be high iff the registered Sum equals 0, regardless of Cout; for example 1111+0000+1 gives Sum 0000, Cout 1, Zero 1.
REQ-017 On a rising clk edge with in_valid=1, Sum, Cout, Ovf and Zero SHALL load the result for the sampled A, B and Cin, and out_valid SHALL go to 1; latency is exactly one cycle.
REQ-018 On a rising clk edge with in_valid=0, Sum, Cout, Ovf and Zero SHALL hold their values and out_valid SHALL go to 0.
REQ-019 Back-to-back in_valid SHALL be accepted every cycle with no stall; there is no backpressure input.
REQ-020 Outputs SHALL depend only on registered state, with no combinational path from inputs to outputs.
REQ-021 X or Z values on A, B or Cin while in_valid=0 SHALL NOT affect the outputs.

Reset
REQ-022 When rst_n=0, Sum, Cout, Ovf, Zero and out_valid SHALL go to 0 immediately, without waiting for clk.
REQ-023 While rst_n=0, clock edges SHALL be ignored, and in_valid SHALL NOT be captured.
REQ-024 The first capture after reset SHALL occur on the first rising clk edge at which rst_n=1 and in_valid=1.
REQ-025 If rst_n asserts in the same cycle as a valid request, that request SHALL be discarded with no partial output update.

Verification
REQ-026 Reset: assert rst_n=0 mid-cycle -> all outputs 0 before the next edge; release, in_valid=0 -> outputs remain 0.
REQ-027 Small sums, one per cycle with in_valid=1:
- 0000+0000+0 -> Sum 0000, Cout 0, Zero 1.
- 0000+0000+1 -> Sum 0001.
- 0001+0001+1 -> Sum 0011, Cout 0.
REQ-028 Carry and overflow:
- 0111+0111+0 -> Sum 1110, Cout 0, Ovf 1.
- 0111+0111+1 -> Sum 1111, Ovf 1.
- 0101+0101+1 -> Sum 1011, Ovf 1.
REQ-029 Wrap-around:
- 1011+1011+0 -> Sum 0110, Cout 1, Ovf 1.
- 1111+1111+0 -> Sum 1110, Cout 1, Ovf 0.
- 1111+1111+1 -> Sum 1111, Cout 1.
REQ-030 Latency and hold: apply 0011+0011+1, then drop in_valid next cycle -> result Sum 0111 appears one edge later with out_valid 1; following edge out_valid 0, Sum stays 0111.
REQ-031 Exhaustive: all 512 combinations of A, B and Cin streamed back-to-back -> every {Cout,Sum} equals A+B+Cin one cycle later, and Ovf and Zero match REQ-015 and REQ-016.

Source files
------------

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: WIDTH full-adder cells feeding a result register
// that also carries carry-out, signed-overflow and zero flags.
module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;

  assign carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_next[gi]  = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi+1]   = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  // Flags are computed from the same cycle's sum so they load together with Sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_next;
        Cout <= carry[WIDTH];
        Ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
        Zero <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: directed, exhaustive and random requests
// compared against an integer-arithmetic reference model.
module tb_four_bit_adder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic         Cin, in_valid;
  logic [W-1:0] Sum;
  logic         Cout, Ovf, Zero, out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_sum, exp_cout, exp_ovf, exp_zero, exp_valid;

  four_bit_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .in_valid(in_valid),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .Zero(Zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic on the operands.
  task automatic model(input int a, input int b, input int cin);
    int total, sa, sb, st;
    total    = a + b + cin;
    exp_sum  = total % M;
    exp_cout = total / M;
    sa       = (a >= M/2) ? a - M : a;
    sb       = (b >= M/2) ? b - M : b;
    st       = sa + sb + cin;
    exp_ovf  = (st > M/2 - 1 || st < -(M/2)) ? 1 : 0;
    exp_zero = (exp_sum == 0) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".sum"},   32'(Sum),       32'(exp_sum));
    check({tag, ".cout"},  32'(Cout),      32'(exp_cout));
    check({tag, ".ovf"},   32'(Ovf),       32'(exp_ovf));
    check({tag, ".zero"},  32'(Zero),      32'(exp_zero));
    check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
  endtask

  task automatic clear_model();
    exp_sum = 0; exp_cout = 0; exp_ovf = 0; exp_zero = 0; exp_valid = 0;
  endtask

  // One request per cycle: drive at negedge, check just after the capturing edge.
  task automatic apply(input string tag, input int a, input int b, input int cin, input bit v);
    @(negedge clk);
    in_valid = v;
    if (v) begin
      A = a[W-1:0]; B = b[W-1:0]; Cin = cin[0];
    end else begin
      A = 'x; B = 'x; Cin = 1'bx;
    end
    @(posedge clk);
    #1;
    if (v) model(a, b, cin);
    exp_valid = v ? 1 : 0;
    $display("txn %s A=%0d B=%0d Cin=%0d v=%0d -> Sum=%0d Cout=%0d Ovf=%0d Zero=%0d out_valid=%0d",
             tag, a, b, cin, v, Sum, Cout, Ovf, Zero, out_valid);
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; Cin = 1'b0; in_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply("idle_after_reset", 0, 0, 0, 0);
    apply("idle_after_reset2", 0, 0, 0, 0);

    // Small sums
    apply("small0", 0, 0, 0, 1);
    apply("small1", 0, 0, 1, 1);
    apply("small2", 1, 1, 1, 1);
    // Carry and overflow
    apply("ovf0", 7, 7, 0, 1);
    apply("ovf1", 7, 7, 1, 1);
    apply("ovf2", 5, 5, 1, 1);
    // Wrap-around
    apply("wrap0", 11, 11, 0, 1);
    apply("wrap1", 15, 15, 0, 1);
    apply("wrap2", 15, 15, 1, 1);
    apply("zero_cout", 15, 0, 1, 1);
    // Latency and hold, with undriven operands while idle
    apply("lat", 3, 3, 1, 1);
    apply("hold", 0, 0, 0, 0);
    apply("hold2", 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with a live request pending
    apply("pre_reset", 15, 15, 1, 1);
    @(negedge clk);
    A = 4'd5; B = 4'd5; Cin = 1'b1; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_ignores_clk");
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("release_idle");
    apply("first_capture", 9, 4, 1, 1);

    // Exhaustive back-to-back stream
    for (int a = 0; a < M; a++)
      for (int b = 0; b < M; b++)
        for (int c = 0; c < 2; c++)
          apply("exh", a, b, c, 1);

    // Random traffic with gaps
    for (int i = 0; i < 200; i++)
      apply("rand", int'($urandom_range(0, M-1)), int'($urandom_range(0, M-1)),
            int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
